// File: rtl/core_pkg.sv
// Shared encodings for the decode/execute slice: opcodes, ALU ops, writeback/branch selectors and field positions.
// Matrix opcodes are decoded only when MATRIX_UNIT_EN is defined.
package core_pkg;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int REG_AW  = $clog2(NREGS);
    localparam int OP_LSB  = 27;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 17;
    localparam int RS2_LSB = 12;
    localparam int IMM_W   = 17;

    typedef enum logic [4:0] {
        OP_NOP      = 5'h00, OP_ADD    = 5'h01, OP_SUB    = 5'h02, OP_AND   = 5'h03,
        OP_OR       = 5'h04, OP_XOR    = 5'h05, OP_SLL    = 5'h06, OP_SRL   = 5'h07,
        OP_SRA      = 5'h08, OP_SLT    = 5'h09, OP_ADDI   = 5'h0A, OP_ANDI  = 5'h0B,
        OP_ORI      = 5'h0C, OP_XORI   = 5'h0D, OP_LW     = 5'h0E, OP_SW    = 5'h0F,
        OP_BEQ      = 5'h10, OP_BNE    = 5'h11, OP_BLT    = 5'h12, OP_JAL   = 5'h13,
        OP_MATLDA   = 5'h14, OP_MATLDB = 5'h15, OP_MATLDC = 5'h16, OP_MATSTART = 5'h17
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR    = 4'd4,
        ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_PASS_B = 4'd9
    } alu_op_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_LT   = 2'b11;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       imm_sel;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] wb_sel;
        logic [1:0] branch_type;
        logic       jal;
        logic       mat_we_a;
        logic       mat_we_b;
        logic       mat_we_c;
        logic       mat_start;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD:  begin c.alu_op = ALU_ADD; c.reg_write = 1'b1; end
            OP_SUB:  begin c.alu_op = ALU_SUB; c.reg_write = 1'b1; end
            OP_AND:  begin c.alu_op = ALU_AND; c.reg_write = 1'b1; end
            OP_OR:   begin c.alu_op = ALU_OR;  c.reg_write = 1'b1; end
            OP_XOR:  begin c.alu_op = ALU_XOR; c.reg_write = 1'b1; end
            OP_SLL:  begin c.alu_op = ALU_SLL; c.reg_write = 1'b1; end
            OP_SRL:  begin c.alu_op = ALU_SRL; c.reg_write = 1'b1; end
            OP_SRA:  begin c.alu_op = ALU_SRA; c.reg_write = 1'b1; end
            OP_SLT:  begin c.alu_op = ALU_SLT; c.reg_write = 1'b1; end
            OP_ADDI: begin c.alu_op = ALU_ADD; c.imm_sel = 1'b1; c.reg_write = 1'b1; end
            OP_ANDI: begin c.alu_op = ALU_AND; c.imm_sel = 1'b1; c.reg_write = 1'b1; end
            OP_ORI:  begin c.alu_op = ALU_OR;  c.imm_sel = 1'b1; c.reg_write = 1'b1; end
            OP_XORI: begin c.alu_op = ALU_XOR; c.imm_sel = 1'b1; c.reg_write = 1'b1; end
            OP_LW:   begin c.imm_sel = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_MEM; end
            OP_SW:   begin c.imm_sel = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:  c.branch_type = BR_EQ;
            OP_BNE:  c.branch_type = BR_NE;
            OP_BLT:  c.branch_type = BR_LT;
            OP_JAL:  begin c.jal = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_PC4; end
`ifdef MATRIX_UNIT_EN
            OP_MATLDA:   begin c.alu_op = ALU_PASS_B; c.mat_we_a = 1'b1; end
            OP_MATLDB:   begin c.alu_op = ALU_PASS_B; c.mat_we_b = 1'b1; end
            OP_MATLDC:   begin c.alu_op = ALU_PASS_B; c.mat_we_c = 1'b1; end
            OP_MATSTART: c.mat_start = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_execute_regfile.sv
// 32x32 register file: two combinational read ports with same-cycle write bypass, r0 hard-wired to zero.
module regfile
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_sel,
    input  logic [REG_AW-1:0] rs2_sel,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_sel,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every entry is cleared on reset, so this array maps to flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_sel != '0) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign rs1_data = (rs1_sel == '0)                 ? '0      :
                      (wr_en && wr_sel == rs1_sel)    ? wr_data : regs[rs1_sel];
    assign rs2_data = (rs2_sel == '0)                 ? '0      :
                      (wr_en && wr_sel == rs2_sel)    ? wr_data : regs[rs2_sel];

endmodule

// File: rtl/decode_execute.sv
// Decode + execute slice: regfile read, decode, ID/EX, forwarded ALU and branch resolve, EX/MEM.
// Matrix-unit strobes are present only when MATRIX_UNIT_EN is defined; otherwise they are tied to 0.
module decode_execute
    import core_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic [XLEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              reg_write_enable_i,
    input  logic [REG_AW-1:0] write_reg_sel_i,
    input  logic [XLEN-1:0]   write_data_i,
    input  logic [1:0]        forward_en_i,
    input  logic [XLEN-1:0]   forward_data_i,
    output logic [REG_AW-1:0] d_op1_reg_o,
    output logic [REG_AW-1:0] d_op2_reg_o,
    output logic [REG_AW-1:0] e_dest_reg_o,
    output logic              e_dest_reg_en_o,
    output logic              e_valid_o,
    output logic [4:0]        row_o,
    output logic [4:0]        col_o,
    output logic              start_o,
    output logic              write_enable_A_o,
    output logic              write_enable_B_o,
    output logic              write_enable_C_o,
    output logic [XLEN-1:0]   result_o,
    output logic [XLEN-1:0]   read_data2_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [1:0]        wb_sel_o,
    output logic              reg_write_enable_o,
    output logic              mem_write_enable_o,
    output logic [REG_AW-1:0] write_reg_sel_o,
    output logic              branch_taken_o,
    output logic [XLEN-1:0]   cout_o
);

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] col;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   cout;
        logic [1:0]        wb_sel;
        logic              reg_write;
        logic              mem_write;
        logic              branch_taken;
        logic [REG_AW-1:0] rd;
    } ex_mem_t;

    logic [REG_AW-1:0] rs1_sel, rs2_sel;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    id_ex_t            id_ex, id_ex_d;
    ex_mem_t           ex_mem, ex_mem_d;

    assign rs1_sel     = instr_i[RS1_LSB +: REG_AW];
    assign rs2_sel     = instr_i[RS2_LSB +: REG_AW];
    assign d_op1_reg_o = rs1_sel;
    assign d_op2_reg_o = rs2_sel;

    regfile u_regfile (
        .clk      (clk_i),
        .rst      (rst_i),
        .rs1_sel  (rs1_sel),
        .rs2_sel  (rs2_sel),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (reg_write_enable_i),
        .wr_sel   (write_reg_sel_i),
        .wr_data  (write_data_i)
    );

    // ---------------- ID ----------------
    always_comb begin
        id_ex_d          = '0;
        id_ex_d.valid    = 1'b1;
        id_ex_d.ctrl     = decode_op(instr_i[OP_LSB +: 5]);
        id_ex_d.rd       = instr_i[RD_LSB +: REG_AW];
        id_ex_d.col      = rs1_sel;
        id_ex_d.rs1_data = rs1_data;
        id_ex_d.rs2_data = rs2_data;
        id_ex_d.imm      = {{(XLEN-IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]};
        id_ex_d.pc       = pc_i;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i || flush_i) id_ex <= '0;
        else if (!stall_i)    id_ex <= id_ex_d;
    end

    // ---------------- EX ----------------
    logic [XLEN-1:0] op_a, rs2_val, op_b, alu_result, pc4, target;
    logic            br_cond;

    assign op_a    = forward_en_i[0] ? forward_data_i : id_ex.rs1_data;
    assign rs2_val = forward_en_i[1] ? forward_data_i : id_ex.rs2_data;
    assign op_b    = id_ex.ctrl.imm_sel ? id_ex.imm : rs2_val;
    assign pc4     = id_ex.pc + XLEN'(4);
    assign target  = id_ex.pc + {id_ex.imm[XLEN-3:0], 2'b00};

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        alu_result = '0;
        case (id_ex.ctrl.alu_op)
            ALU_ADD:    alu_result = op_a + op_b;
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_AND:    alu_result = op_a & op_b;
            ALU_OR:     alu_result = op_a | op_b;
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_SLL:    alu_result = op_a << op_b[4:0];
            ALU_SRL:    alu_result = op_a >> op_b[4:0];
            ALU_SRA:    alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_PASS_B: alu_result = op_b;
            default:    alu_result = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (id_ex.ctrl.branch_type)
            BR_EQ:   br_cond = (op_a == rs2_val);
            BR_NE:   br_cond = (op_a != rs2_val);
            BR_LT:   br_cond = ($signed(op_a) < $signed(rs2_val));
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ex_mem_d              = '0;
        ex_mem_d.result       = id_ex.ctrl.jal ? pc4 : alu_result;
        ex_mem_d.rd2          = rs2_val;
        ex_mem_d.pc           = id_ex.pc;
        ex_mem_d.cout         = target;
        ex_mem_d.wb_sel       = id_ex.ctrl.wb_sel;
        ex_mem_d.reg_write    = id_ex.valid & id_ex.ctrl.reg_write;
        ex_mem_d.mem_write    = id_ex.valid & id_ex.ctrl.mem_write;
        ex_mem_d.branch_taken = id_ex.valid & (id_ex.ctrl.jal | br_cond);
        ex_mem_d.rd           = id_ex.rd;
    end

    // A stalled EX stage emits a bubble unless a flush is pushing it forward.
    always_ff @(posedge clk_i) begin
        if (rst_i || (stall_i && !flush_i)) ex_mem <= '0;
        else                                ex_mem <= ex_mem_d;
    end

    assign e_dest_reg_o    = id_ex.rd;
    assign e_dest_reg_en_o = id_ex.valid & id_ex.ctrl.reg_write;
    assign e_valid_o       = id_ex.valid;

    assign result_o           = ex_mem.result;
    assign read_data2_o       = ex_mem.rd2;
    assign pc_o               = ex_mem.pc;
    assign cout_o             = ex_mem.cout;
    assign wb_sel_o           = ex_mem.wb_sel;
    assign reg_write_enable_o = ex_mem.reg_write;
    assign mem_write_enable_o = ex_mem.mem_write;
    assign branch_taken_o     = ex_mem.branch_taken;
    assign write_reg_sel_o    = ex_mem.rd;

`ifdef MATRIX_UNIT_EN
    // Strobes fire on the single cycle the instruction leaves EX; stall and flush hold them off.
    logic mat_fire;
    assign mat_fire         = id_ex.valid & ~stall_i & ~flush_i;
    assign row_o            = id_ex.rd;
    assign col_o            = id_ex.col;
    assign start_o          = mat_fire & id_ex.ctrl.mat_start;
    assign write_enable_A_o = mat_fire & id_ex.ctrl.mat_we_a;
    assign write_enable_B_o = mat_fire & id_ex.ctrl.mat_we_b;
    assign write_enable_C_o = mat_fire & id_ex.ctrl.mat_we_c;
`else
    logic unused_mat;
    assign unused_mat       = ^{id_ex.col, id_ex.ctrl.mat_we_a, id_ex.ctrl.mat_we_b,
                                id_ex.ctrl.mat_we_c, id_ex.ctrl.mat_start};
    assign row_o            = '0;
    assign col_o            = '0;
    assign start_o          = 1'b0;
    assign write_enable_A_o = 1'b0;
    assign write_enable_B_o = 1'b0;
    assign write_enable_C_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_execute.sv
// Directed self-checking bench for decode_execute; matrix expectations follow MATRIX_UNIT_EN.
module tb_decode_execute;

    localparam logic [4:0] ADD = 5'h01, SUB = 5'h02, OR_ = 5'h04, SLL = 5'h06, ADDI = 5'h0A;
    localparam logic [4:0] LW = 5'h0E, SW = 5'h0F, BEQ = 5'h10, BNE = 5'h11, BLT = 5'h12;
    localparam logic [4:0] JAL = 5'h13, MATLDB = 5'h15, MATSTART = 5'h17;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, stall_i;
    logic [31:0] instr_i, pc_i;
    logic        reg_write_enable_i;
    logic [4:0]  write_reg_sel_i;
    logic [31:0] write_data_i;
    logic [1:0]  forward_en_i;
    logic [31:0] forward_data_i;
    logic [4:0]  d_op1_reg_o, d_op2_reg_o, e_dest_reg_o;
    logic        e_dest_reg_en_o, e_valid_o;
    logic [4:0]  row_o, col_o;
    logic        start_o, write_enable_A_o, write_enable_B_o, write_enable_C_o;
    logic [31:0] result_o, read_data2_o, pc_o, cout_o;
    logic [1:0]  wb_sel_o;
    logic        reg_write_enable_o, mem_write_enable_o, branch_taken_o;
    logic [4:0]  write_reg_sel_o;

    int n_checks = 0;
    int n_errors = 0;

    decode_execute dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .instr_i(instr_i), .pc_i(pc_i),
        .reg_write_enable_i(reg_write_enable_i), .write_reg_sel_i(write_reg_sel_i),
        .write_data_i(write_data_i),
        .forward_en_i(forward_en_i), .forward_data_i(forward_data_i),
        .d_op1_reg_o(d_op1_reg_o), .d_op2_reg_o(d_op2_reg_o),
        .e_dest_reg_o(e_dest_reg_o), .e_dest_reg_en_o(e_dest_reg_en_o), .e_valid_o(e_valid_o),
        .row_o(row_o), .col_o(col_o), .start_o(start_o),
        .write_enable_A_o(write_enable_A_o), .write_enable_B_o(write_enable_B_o),
        .write_enable_C_o(write_enable_C_o),
        .result_o(result_o), .read_data2_o(read_data2_o), .pc_o(pc_o),
        .wb_sel_o(wb_sel_o), .reg_write_enable_o(reg_write_enable_o),
        .mem_write_enable_o(mem_write_enable_o), .write_reg_sel_o(write_reg_sel_o),
        .branch_taken_o(branch_taken_o), .cout_o(cout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] r_type(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 12'h000};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] op, rd, rs1, input logic [16:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] sel, input logic [31:0] data);
        reg_write_enable_i = 1'b1;
        write_reg_sel_i    = sel;
        write_data_i       = data;
        tick();
        reg_write_enable_i = 1'b0;
    endtask

    // Loads one instruction into ID/EX and leaves a NOP on the fetch side.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        instr_i = instr;
        pc_i    = pc;
        tick();
        instr_i = 32'h0;
        pc_i    = 32'h0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        instr_i = r_type(ADD, 5'd3, 5'd1, 5'd2);
        tick();
        tick();
        n_checks++; if (result_o !== 32'h0 || pc_o !== 32'h0 || cout_o !== 32'h0 || read_data2_o !== 32'h0) begin
            n_errors++; $display("FAIL reset_data result=%h pc=%h cout=%h rd2=%h expected all 0", result_o, pc_o, cout_o, read_data2_o); end
        n_checks++; if ({reg_write_enable_o, mem_write_enable_o, branch_taken_o, wb_sel_o, write_reg_sel_o} !== 10'h0) begin
            n_errors++; $display("FAIL reset_ctrl got %b expected 0", {reg_write_enable_o, mem_write_enable_o, branch_taken_o, wb_sel_o, write_reg_sel_o}); end
        n_checks++; if ({e_valid_o, e_dest_reg_en_o, e_dest_reg_o} !== 7'h0) begin
            n_errors++; $display("FAIL reset_hazard got %b expected 0", {e_valid_o, e_dest_reg_en_o, e_dest_reg_o}); end
        n_checks++; if ({row_o, col_o, start_o, write_enable_A_o, write_enable_B_o, write_enable_C_o} !== 14'h0) begin
            n_errors++; $display("FAIL reset_matrix got %b expected 0", {row_o, col_o, start_o, write_enable_A_o, write_enable_B_o, write_enable_C_o}); end
        n_checks++; if (d_op1_reg_o !== 5'd1 || d_op2_reg_o !== 5'd2) begin
            n_errors++; $display("FAIL decode_srcs got %0d,%0d expected 1,2", d_op1_reg_o, d_op2_reg_o); end
        rst_i = 1'b0;
        for (int i = 1; i < 32; i++) begin
            issue(r_type(OR_, 5'd1, 5'(i), 5'(i)), 32'h0);
            tick();
            n_checks++; if (result_o !== 32'h0) begin
                n_errors++; $display("FAIL reset_reg r%0d got %h expected 0", i, result_o); end
        end
    endtask

    task automatic test_alu();
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd7);
        issue(r_type(ADD, 5'd3, 5'd1, 5'd2), 32'h0);
        n_checks++; if (e_dest_reg_o !== 5'd3 || e_dest_reg_en_o !== 1'b1 || e_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL add_hazard dest=%0d en=%b valid=%b expected 3,1,1", e_dest_reg_o, e_dest_reg_en_o, e_valid_o); end
        tick();
        n_checks++; if (result_o !== 32'd12 || write_reg_sel_o !== 5'd3 || reg_write_enable_o !== 1'b1 || wb_sel_o !== 2'b00) begin
            n_errors++; $display("FAIL add result=%h sel=%0d we=%b wb=%b expected 0000000c,3,1,00", result_o, write_reg_sel_o, reg_write_enable_o, wb_sel_o); end
        issue(r_type(SUB, 5'd3, 5'd1, 5'd2), 32'h0);
        tick();
        n_checks++; if (result_o !== 32'hFFFF_FFFE) begin
            n_errors++; $display("FAIL sub got %h expected fffffffe", result_o); end
        issue(i_type(ADDI, 5'd4, 5'd1, 17'h1FFFF), 32'h0);
        tick();
        n_checks++; if (result_o !== 32'd4 || write_reg_sel_o !== 5'd4) begin
            n_errors++; $display("FAIL addi got %h sel=%0d expected 00000004,4", result_o, write_reg_sel_o); end
        issue(r_type(SLL, 5'd5, 5'd1, 5'd2), 32'h0);
        tick();
        n_checks++; if (result_o !== 32'h280) begin
            n_errors++; $display("FAIL sll got %h expected 00000280", result_o); end
        issue(i_type(LW, 5'd6, 5'd1, 17'd8), 32'h0);
        tick();
        n_checks++; if (result_o !== 32'd13 || wb_sel_o !== 2'b01 || reg_write_enable_o !== 1'b1) begin
            n_errors++; $display("FAIL lw addr=%h wb=%b we=%b expected 0000000d,01,1", result_o, wb_sel_o, reg_write_enable_o); end
        // Writeback to r9 in the same cycle it is read must be bypassed.
        reg_write_enable_i = 1'b1; write_reg_sel_i = 5'd9; write_data_i = 32'h55;
        issue(r_type(ADD, 5'd10, 5'd9, 5'd0), 32'h0);
        reg_write_enable_i = 1'b0;
        tick();
        n_checks++; if (result_o !== 32'h55) begin
            n_errors++; $display("FAIL rf_bypass got %h expected 00000055", result_o); end
        write_reg(5'd0, 32'h1234);
        issue(r_type(OR_, 5'd1, 5'd0, 5'd0), 32'h0);
        tick();
        n_checks++; if (result_o !== 32'h0) begin
            n_errors++; $display("FAIL r0_zero got %h expected 0", result_o); end
    endtask

    task automatic test_forwarding();
        issue(r_type(ADD, 5'd3, 5'd1, 5'd2), 32'h0);
        forward_en_i = 2'b01; forward_data_i = 32'd100;
        tick();
        forward_en_i = 2'b00;
        n_checks++; if (result_o !== 32'd107) begin
            n_errors++; $display("FAIL fwd_op1 got %h expected 0000006b", result_o); end
        issue(i_type(SW, 5'd0, 5'd1, 17'h02004), 32'h0);
        forward_en_i = 2'b10; forward_data_i = 32'hDEAD_BEEF;
        tick();
        forward_en_i = 2'b00;
        n_checks++; if (read_data2_o !== 32'hDEAD_BEEF || mem_write_enable_o !== 1'b1 || reg_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL fwd_store rd2=%h mw=%b we=%b expected deadbeef,1,0", read_data2_o, mem_write_enable_o, reg_write_enable_o); end
        n_checks++; if (result_o !== 32'h2009) begin
            n_errors++; $display("FAIL sw_addr got %h expected 00002009", result_o); end
    endtask

    task automatic test_flush();
        instr_i = r_type(ADD, 5'd3, 5'd1, 5'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; instr_i = 32'h0;
        n_checks++; if (e_valid_o !== 1'b0 || e_dest_reg_en_o !== 1'b0) begin
            n_errors++; $display("FAIL flush_idex valid=%b en=%b expected 0,0", e_valid_o, e_dest_reg_en_o); end
        tick();
        n_checks++; if (reg_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL flush_exmem we=%b expected 0", reg_write_enable_o); end
        issue(r_type(ADD, 5'd11, 5'd1, 5'd2), 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (reg_write_enable_o !== 1'b1 || result_o !== 32'd12 || write_reg_sel_o !== 5'd11 || e_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL flush_ex_passes we=%b res=%h sel=%0d valid=%b expected 1,0000000c,11,0", reg_write_enable_o, result_o, write_reg_sel_o, e_valid_o); end
    endtask

    task automatic test_stall();
        issue(r_type(SUB, 5'd7, 5'd1, 5'd2), 32'h0);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (e_dest_reg_o !== 5'd7 || e_valid_o !== 1'b1 || reg_write_enable_o !== 1'b0) begin
                n_errors++; $display("FAIL stall_%0d dest=%0d valid=%b we=%b expected 7,1,0", i, e_dest_reg_o, e_valid_o, reg_write_enable_o); end
        end
        stall_i = 1'b0;
        tick();
        n_checks++; if (result_o !== 32'hFFFF_FFFE || reg_write_enable_o !== 1'b1 || write_reg_sel_o !== 5'd7) begin
            n_errors++; $display("FAIL stall_release res=%h we=%b sel=%0d expected fffffffe,1,7", result_o, reg_write_enable_o, write_reg_sel_o); end
        tick();
        n_checks++; if (reg_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL stall_once we=%b expected 0", reg_write_enable_o); end
    endtask

    task automatic test_branch();
        issue(i_type(BEQ, 5'd0, 5'd0, 17'd4), 32'h100);
        tick();
        n_checks++; if (branch_taken_o !== 1'b1 || cout_o !== 32'h110 || pc_o !== 32'h100 || reg_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL beq taken=%b cout=%h pc=%h we=%b expected 1,00000110,00000100,0", branch_taken_o, cout_o, pc_o, reg_write_enable_o); end
        issue(i_type(BNE, 5'd0, 5'd1, 17'd4), 32'h100);
        tick();
        n_checks++; if (branch_taken_o !== 1'b1 || cout_o !== 32'h110) begin
            n_errors++; $display("FAIL bne taken=%b cout=%h expected 1,00000110", branch_taken_o, cout_o); end
        issue(i_type(BLT, 5'd0, 5'd1, 17'd4), 32'h100);
        tick();
        n_checks++; if (branch_taken_o !== 1'b0) begin
            n_errors++; $display("FAIL blt_not_taken got %b expected 0", branch_taken_o); end
        write_reg(5'd12, 32'hFFFF_FFF0);
        issue(i_type(BLT, 5'd0, 5'd12, 17'd4), 32'h100);
        tick();
        n_checks++; if (branch_taken_o !== 1'b1) begin
            n_errors++; $display("FAIL blt_signed got %b expected 1", branch_taken_o); end
        issue(i_type(BLT, 5'd0, 5'd0, 17'd4), 32'h40);
        forward_en_i = 2'b10; forward_data_i = 32'd5;
        tick();
        forward_en_i = 2'b00;
        n_checks++; if (branch_taken_o !== 1'b1 || cout_o !== 32'h50) begin
            n_errors++; $display("FAIL blt_fwd taken=%b cout=%h expected 1,00000050", branch_taken_o, cout_o); end
        issue(i_type(JAL, 5'd8, 5'd0, 17'h1FFFF), 32'h200);
        tick();
        n_checks++; if (branch_taken_o !== 1'b1 || cout_o !== 32'h1FC || result_o !== 32'h204 || wb_sel_o !== 2'b10 || reg_write_enable_o !== 1'b1 || write_reg_sel_o !== 5'd8) begin
            n_errors++; $display("FAIL jal taken=%b cout=%h res=%h wb=%b we=%b sel=%0d expected 1,000001fc,00000204,10,1,8", branch_taken_o, cout_o, result_o, wb_sel_o, reg_write_enable_o, write_reg_sel_o); end
    endtask

    task automatic test_matrix();
        issue(r_type(MATLDB, 5'd3, 5'd4, 5'd2), 32'h0);
`ifdef MATRIX_UNIT_EN
        n_checks++; if (write_enable_B_o !== 1'b1 || row_o !== 5'd3 || col_o !== 5'd4 || write_enable_A_o !== 1'b0 || write_enable_C_o !== 1'b0 || start_o !== 1'b0) begin
            n_errors++; $display("FAIL matldb_ex weB=%b row=%0d col=%0d weA=%b weC=%b start=%b expected 1,3,4,0,0,0", write_enable_B_o, row_o, col_o, write_enable_A_o, write_enable_C_o, start_o); end
        tick();
        n_checks++; if (write_enable_B_o !== 1'b0 || result_o !== 32'd7 || reg_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL matldb_mem weB=%b res=%h we=%b expected 0,00000007,0", write_enable_B_o, result_o, reg_write_enable_o); end
        issue(r_type(MATSTART, 5'd0, 5'd0, 5'd0), 32'h0);
        n_checks++; if (start_o !== 1'b1) begin
            n_errors++; $display("FAIL matstart got %b expected 1", start_o); end
        tick();
        n_checks++; if (start_o !== 1'b0) begin
            n_errors++; $display("FAIL matstart_pulse got %b expected 0", start_o); end
`else
        n_checks++; if ({write_enable_B_o, row_o, col_o} !== 11'h0) begin
            n_errors++; $display("FAIL matldb_disabled got %b expected 0", {write_enable_B_o, row_o, col_o}); end
        tick();
        n_checks++; if (reg_write_enable_o !== 1'b0 || mem_write_enable_o !== 1'b0) begin
            n_errors++; $display("FAIL matldb_nop we=%b mw=%b expected 0,0", reg_write_enable_o, mem_write_enable_o); end
        issue(r_type(MATSTART, 5'd0, 5'd0, 5'd0), 32'h0);
        n_checks++; if (start_o !== 1'b0) begin
            n_errors++; $display("FAIL matstart_disabled got %b expected 0", start_o); end
        tick();
`endif
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        instr_i = 32'h0; pc_i = 32'h0;
        reg_write_enable_i = 1'b0; write_reg_sel_i = 5'd0; write_data_i = 32'h0;
        forward_en_i = 2'b00; forward_data_i = 32'h0;
        test_reset();
        test_alu();
        test_forwarding();
        test_flush();
        test_stall();
        test_branch();
        test_matrix();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_execute.md
Name: decode_execute

Overview:
- Decode plus execute pipeline slice of the 32-bit core: register file, instruction decode and immediate generation, ID/EX register, ALU with forwarding muxes, EX/MEM register.
- Sits between fetch (instr_i/pc_i) and memory/writeback.
- Exports hazard info to the hazard unit and control strobes to the matrix (systolic) unit.

Parameters:
- XLEN, 32, datapath/register width.
- NREGS, 32, register count; r0 reads as 0.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: synchronous active-high reset.
- flush_i, stall_i in 1: pipeline control.
- instr_i in 32: instruction.
- pc_i in 32: its PC.
- reg_write_enable_i in 1, write_reg_sel_i in 5, write_data_i in 32: writeback port.
- forward_en_i in 2: bit0 overrides op1, bit1 overrides op2/store data.
- forward_data_i in 32: forwarded value.
- d_op1_reg_o, d_op2_reg_o out 5: rs1/rs2 of instr_i (combinational).
- e_dest_reg_o out 5, e_dest_reg_en_o out 1, e_valid_o out 1: rd, write enable and valid of the instruction in EX.
- row_o, col_o out 5; start_o, write_enable_A_o, write_enable_B_o, write_enable_C_o out 1: matrix controls from ID/EX.
- result_o out 32, read_data2_o out 32, pc_o out 32: EX/MEM data.
- wb_sel_o out 2, reg_write_enable_o out 1, mem_write_enable_o out 1, write_reg_sel_o out 5: EX/MEM controls.
- branch_taken_o out 1, cout_o out 32: branch outcome and target, EX/MEM.

Behaviour:
- Instruction format:
  - op=[31:27], rd=[26:22], rs1=[21:17], rs2=[16:12].
  - imm = sign-extended [16:0].
  - Branches use imm<<2.
- Opcodes:
  - 00 NOP.
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 SLL, 07 SRL, 08 SRA, 09 SLT (signed). All register-register.
  - 0A ADDI, 0B ANDI, 0C ORI, 0D XORI.
  - 0E LW: addr = rs1+imm, wb_sel=01.
  - 0F SW: mem_write, store data = rs2.
  - 10 BEQ, 11 BNE, 12 BLT: branch_type 01/10/11, no register write.
  - 13 JAL: wb_sel=10, rd = pc+4, always taken.
  - 14/15/16 MATLDA/B/C: row=rd field, col=rs1 field, result_o = rs2 data, assert write_enable_A/B/C.
  - 17 MATSTART: start_o.
  - Undefined opcodes decode as NOP.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 PASS_B.
- Shifts use operand B[4:0]. Arithmetic wraps mod 2^32.
- Register file:
  - Written at posedge when reg_write_enable_i is set and write_reg_sel_i != 0.
  - Same-cycle read of the register being written returns write_data_i (bypass).
  - r0 is always 0.
  - Reset clears all registers.
- Timing:
  - ID/EX register loads at posedge. EX is combinational on ID/EX. EX/MEM register loads at the next posedge.
  - Latency from instr_i to result_o is 2 cycles.
- Forwarding:
  - When forward_en_i[0]=1, op1 = forward_data_i.
  - When forward_en_i[1]=1, the rs2 value = forward_data_i. This applies to the ALU operand (when imm_sel=0) and to read_data2_o.
- Branches:
  - cout_o = pc + (imm<<2).
  - branch_taken_o per branch_type compare of forwarded operands. JAL is always taken.
- Pipeline control:
  - stall_i: ID/EX holds; EX/MEM loads a bubble (all enables 0, e_valid_o unaffected since ID/EX holds).
  - flush_i: ID/EX loads a bubble (valid=0, all enables 0). EX/MEM loads normally.
  - flush_i wins over stall_i.
- Hazard outputs:
  - e_dest_reg_o is ID/EX rd.
  - e_dest_reg_en_o = ID/EX reg_write_enable AND valid.
- Reset: every registered output is 0, including pc_o, result_o and all enables; valid=0.
- Matrix strobes are valid for one cycle per instruction in EX. They are suppressed by flush_i.

Optional Feature:
- MATRIX_UNIT_EN defined: opcodes 14–17 behave as above.
- Undefined: those opcodes decode as NOP. row_o, col_o, start_o and the write_enable_A/B/C_o outputs are tied to 0 (no matrix logic).

Decomposition:
- Package core_pkg: opcode enum, alu_op enum, wb_sel and branch_type encodings, field-position constants.
- Sub-module regfile: 32x32 register file with bypass.
- ALU is inline.

Test Plan:
- Reset: hold rst_i 2 cycles with instr ADD -> all outputs 0; r1..r31 read 0.
- ALU: write r1=5, r2=7 via writeback port; issue ADD r3,r1,r2 -> after 2 cycles result_o=12, write_reg_sel_o=3, reg_write_enable_o=1. Also SUB -> 0xFFFFFFFE. Also ADDI r4,r1,-1 -> 4.
- Forwarding: ADD with forward_en_i=01, forward_data_i=100, r2=7 -> result_o=107. Also forward_en_i=10 on SW -> read_data2_o=forward value.
- Flush: issue ADD then assert flush_i -> next EX/MEM has reg_write_enable_o=0, e_valid_o=0.
- Stall: stall_i 2 cycles during SUB -> e_dest_reg_o constant; EX/MEM bubbles; the result appears once, after the stall releases.
- Branch/matrix: pc=0x100, BEQ r1,r1,imm=4 -> branch_taken_o=1, cout_o=0x110. MATLDB row3 col4 -> write_enable_B_o pulse with row_o=3, col_o=4.
